// File: rtl/accum_scan_calc.sv
// ---------------------------------------------------------------------------
// accum_scan_calc
//
// Push-button accumulator calculator with a multiplexed hex display.
// A raw "execute" button is synchronized, debounced and turned into a
// single-cycle enable pulse per press. Each pulse adds or subtracts the
// operand into a W-bit accumulator and can set a sticky overflow/borrow
// flag. The accumulator is shown on DIGITS active-low seven-segment digits,
// which are scanned one at a time.
//
// Parameters
//   W          accumulator / operand width (4..16)
//   DIGITS     number of hex digits on the display (DIGITS*4 >= W)
//   SCAN_DIV   clock cycles each digit stays enabled (>= 2)
//   DEB_CYCLES consecutive stable cycles to accept a button change (>= 1)
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous, active-low reset
//   btn      raw asynchronous push-button
//   op       0 = add, 1 = subtract (sampled with the enable pulse)
//   clr      synchronous accumulator clear (wins over a coincident press)
//   operand  W-bit operand (sampled with the enable pulse)
//   value    accumulator register
//   ovf_led  sticky overflow / borrow flag
//   seg      active-low segments {g,f,e,d,c,b,a}
//   an       active-low one-hot digit enables, an[i] shows nibble i
// ---------------------------------------------------------------------------
module accum_scan_calc #(
    parameter int W          = 8,
    parameter int DIGITS     = 2,
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              op,
    input  logic              clr,
    input  logic [W-1:0]      operand,
    output logic [W-1:0]      value,
    output logic              ovf_led,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int IX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int XW   = DIGITS * 4;

    localparam logic [DC_W-1:0] DEB_LAST  = DC_W'(DEB_CYCLES - 1);
    localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [IX_W-1:0] IDX_LAST  = IX_W'(DIGITS - 1);

    generate
        if (DIGITS * 4 < W) begin : g_bad_digits
            $error("accum_scan_calc: DIGITS*4 must be >= W");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Button synchronizer and debouncer
    // -----------------------------------------------------------------------
    logic            s1, s2;
    logic            deb, deb_q;
    logic [DC_W-1:0] deb_cnt;
    logic            enb;

    // NOTE: every register uses non-blocking assignment so all flops sample
    // the pre-edge values; blocking here would collapse s1/s2 into one stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any agreeing cycle restarts the stability window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            deb_q <= deb;
            if (s2 != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= s2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Rising edge of the accepted level: one pulse per press, none on release.
    assign enb = deb & ~deb_q;

    // -----------------------------------------------------------------------
    // Accumulator
    // -----------------------------------------------------------------------
    logic [W-1:0] acc;
    logic         ovf;
    logic [W:0]   sum;
    logic [W-1:0] diff;
    logic         borrow;

    // NOTE: combinational blocks assign every output first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        sum    = {1'b0, acc} + {1'b0, operand};
        diff   = acc - operand;
        borrow = (operand > acc);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            // A press landing in the same cycle is dropped, not queued.
            acc <= '0;
            ovf <= 1'b0;
        end else if (enb) begin
            if (!op) begin
                acc <= sum[W-1:0];
                ovf <= ovf | sum[W];
            end else begin
                acc <= diff;
                ovf <= ovf | borrow;
            end
        end
    end

    assign value   = acc;
    assign ovf_led = ovf;

    // -----------------------------------------------------------------------
    // Display scan
    // -----------------------------------------------------------------------
    logic [SC_W-1:0] scan_cnt;
    logic [IX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    logic [XW-1:0]     acc_ext;
    logic [3:0]        nibble;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] an_next;

    always_comb begin
        acc_ext  = XW'(acc);
        nibble   = 4'(acc_ext >> (4 * idx));
        seg_next = hex_glyph(nibble);
        an_next  = ~(DIGITS'(1) << idx);
    end

    // Registered display outputs; reset shows digit 0 with a "0" glyph.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg <= 7'b1000000;
            an  <= ~DIGITS'(1);
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_accum_scan_calc.sv
// ---------------------------------------------------------------------------
// tb_accum_scan_calc
//
// Directed bench for accum_scan_calc (W=8, DIGITS=2, SCAN_DIV=4,
// DEB_CYCLES=4). Stimulus tasks push the expected accumulator/flag update,
// including the edge at which it must appear, into a queue. A monitor
// watches {value, ovf_led} on every falling edge and pops one entry per
// observed change; a change with nothing queued is flagged.
// ---------------------------------------------------------------------------
module tb_accum_scan_calc;

    localparam int W    = 8;
    localparam int DIG  = 2;
    localparam int SDIV = 4;
    localparam int DEB  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           btn;
    logic           op;
    logic           clr;
    logic [W-1:0]   operand;
    logic [W-1:0]   value;
    logic           ovf_led;
    logic [6:0]     seg;
    logic [DIG-1:0] an;

    accum_scan_calc #(
        .W          (W),
        .DIGITS     (DIG),
        .SCAN_DIV   (SDIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .op      (op),
        .clr     (clr),
        .operand (operand),
        .value   (value),
        .ovf_led (ovf_led),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     name, act, exp, edge_cnt);
        end
    endtask

    typedef struct {
        logic [W-1:0] v;
        logic         o;
        int           e;
    } exp_t;

    exp_t         exp_q[$];
    logic         mon_en = 1'b0;
    logic [W:0]   prev;

    task automatic push(input logic [W-1:0] v, input logic o, input int e);
        exp_t x;
        x.v = v;
        x.o = o;
        x.e = e;
        exp_q.push_back(x);
    endtask

    // Monitor: every change of {value, ovf_led} must match the next entry.
    always @(negedge clk) begin
        exp_t x;
        if (mon_en && ({value, ovf_led} !== prev)) begin
            if (exp_q.size() == 0) begin
                check("spurious_update", {23'd0, value, ovf_led}, {23'd0, prev});
            end else begin
                x = exp_q.pop_front();
                check("upd_value", 32'(value), 32'(x.v));
                check("upd_ovf",   32'(ovf_led), 32'(x.o));
                check("upd_edge",  32'(edge_cnt), 32'(x.e));
            end
        end
        prev = {value, ovf_led};
    end

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A press whose level is held for `hold` cycles; the update must land
    // DEB+3 edges after the first edge that samples btn high.
    task automatic press(input logic o, input logic [W-1:0] opd,
                         input logic [W-1:0] ev, input logic eo,
                         input int hold);
        @(negedge clk);
        op      = o;
        operand = opd;
        btn     = 1'b1;
        push(ev, eo, edge_cnt + DEB + 3);
        idle(hold);
        btn = 1'b0;
        wait_drain();
        idle(DEB + 8);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        push('0, 1'b0, edge_cnt + 1);
        @(negedge clk);
        clr = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DIG-1:0] first_an;
        logic [DIG-1:0] exp_an;
        logic           found;
        int             base;

        rst = 1'b0; btn = 1'b0; op = 1'b0; clr = 1'b0; operand = '0;

        // Reset state
        idle(3);
        check("rst_value", 32'(value), 32'h0);
        check("rst_ovf",   32'(ovf_led), 32'h0);
        check("rst_an",    32'(an), 32'b10);
        check("rst_seg",   32'(seg), 32'b1000000);
        rst = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Simple add, first-press latency
        press(1'b0, 8'h05, 8'h05, 1'b0, 10);

        // Carry sets the sticky flag; a clean add keeps it
        pulse_clr();
        press(1'b0, 8'hF0, 8'hF0, 1'b0, 10);
        press(1'b0, 8'h20, 8'h10, 1'b1, 10);
        press(1'b0, 8'h01, 8'h11, 1'b1, 10);

        // Borrow on subtract, then clear
        pulse_clr();
        press(1'b0, 8'h03, 8'h03, 1'b0, 10);
        press(1'b1, 8'h05, 8'hFE, 1'b1, 10);
        pulse_clr();

        // Glitch of DEB-1 cycles is ignored
        @(negedge clk);
        op = 1'b0; operand = 8'h01; btn = 1'b1;
        idle(DEB - 1);
        btn = 1'b0;
        idle(20);
        check("glitch_value", 32'(value), 32'h0);
        check("glitch_ovf",   32'(ovf_led), 32'h0);

        // Exactly DEB cycles is the shortest accepted press
        press(1'b0, 8'h01, 8'h01, 1'b0, DEB);

        // Long hold produces a single operation
        press(1'b0, 8'h02, 8'h03, 1'b0, 1000);

        // Display scan with acc = A7
        pulse_clr();
        press(1'b0, 8'hA7, 8'hA7, 1'b0, 10);
        found = 1'b0;
        first_an = an;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== first_an) begin
                found = 1'b1;
                break;
            end
        end
        check("scan_found", 32'(found), 32'd1);
        first_an = an;
        check("scan_an_onehot", 32'((first_an == 2'b10) || (first_an == 2'b01)), 32'd1);
        for (int p = 0; p < 6; p++) begin
            exp_an = (p % 2 == 0) ? first_an : ~first_an;
            for (int c = 0; c < SDIV; c++) begin
                if (p != 0 || c != 0) @(negedge clk);
                check("scan_an", 32'(an), 32'(exp_an));
                check("scan_seg", 32'(seg),
                      (exp_an == 2'b10) ? 32'b1111000 : 32'b0001000);
            end
        end

        // clr coinciding with the enable pulse discards the operation
        @(negedge clk);
        op = 1'b0; operand = 8'h11; btn = 1'b1;
        base = edge_cnt;
        idle(DEB + 2);
        clr = 1'b1;
        push('0, 1'b0, base + DEB + 3);
        @(negedge clk);
        clr = 1'b0;
        idle(10);
        btn = 1'b0;
        wait_drain();
        idle(20);
        check("clr_enb_value", 32'(value), 32'h0);
        check("clr_enb_ovf",   32'(ovf_led), 32'h0);

        // Reset in the middle of a scan returns to digit 0
        press(1'b0, 8'h33, 8'h33, 1'b0, 10);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an === 2'b01) begin
                found = 1'b1;
                break;
            end
        end
        check("scan_digit1_seen", 32'(found), 32'd1);
        rst = 1'b0;
        push('0, 1'b0, edge_cnt + 1);
        @(negedge clk);
        check("midscan_rst_an",  32'(an), 32'b10);
        check("midscan_rst_seg", 32'(seg), 32'b1000000);
        wait_drain();

        // Button held through reset release counts as a fresh press
        op = 1'b0; operand = 8'h09; btn = 1'b1;
        idle(5);
        rst = 1'b1;
        push(8'h09, 1'b0, edge_cnt + DEB + 3);
        idle(12);
        btn = 1'b0;
        wait_drain();
        idle(20);
        check("held_rst_value", 32'(value), 32'h09);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_scan_calc.md
ACCUM_SCAN_CALC -- requirements
Module: accum_scan_calc

Interface
REQ-001 SHALL have parameter W, default 8: accumulator and operand width in bits (legal range 4..16).
REQ-002 SHALL have parameter DIGITS, default 2: number of hex display digits; DIGITS*4 >= W is mandatory.
REQ-003 SHALL have parameter SCAN_DIV, default 100000: clock cycles each digit stays enabled (>= 2).
REQ-004 SHALL have parameter DEB_CYCLES, default 4: consecutive stable cycles needed to accept a button level change (>= 1).
REQ-005 SHALL have port clk  input  1: single system clock; every register is updated on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous and active-low.
REQ-007 SHALL have port btn  input  1: raw, asynchronous "execute" push-button.
REQ-008 SHALL have port op  input  1: 0 = add, 1 = subtract; sampled in the enb cycle.
REQ-009 SHALL have port clr  input  1: synchronous accumulator clear, already synchronous to clk.
REQ-010 SHALL have port operand  input  W: operand; sampled in the enb cycle.
REQ-011 SHALL have port value  output  W: current accumulator.
REQ-012 SHALL have port ovf_led  output  1: sticky overflow/borrow flag.
REQ-013 SHALL have port seg  output  7: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-014 SHALL have port an  output  DIGITS: active-low one-hot digit enables; an[i] selects acc nibble i.

Function
REQ-015 btn SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-016 Debounce: a counter SHALL increment on each edge while s2 != deb; when it equals DEB_CYCLES-1 on a mismatching edge, deb <= s2 and the counter clears; any edge with s2 == deb SHALL clear the counter.
REQ-017 enb SHALL be deb & ~deb_q (deb_q = deb delayed one cycle): exactly one pulse per accepted press, none on release.
REQ-018 Latency: counting the first edge sampling btn=1 as edge 1, with btn held stable, value SHALL update at edge DEB_CYCLES+3 (edge 7 at default).
REQ-019 On enb with op=0: acc <= (acc + operand) mod 2^W; ovf set if the carry-out is 1.
REQ-020 On enb with op=1: acc <= (acc - operand) mod 2^W; ovf set if operand > acc (borrow).
REQ-021 ovf SHALL be sticky: cleared only by clr or reset; a non-overflowing operation leaves it unchanged.
REQ-022 clr SHALL set acc=0 and ovf=0 at the next edge; clr and enb in the same cycle: clr wins and the operation is discarded.
REQ-023 A press whose enb falls during clr SHALL be lost, not deferred.
REQ-024 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on the wrap edge, digit index advances i -> (i+1) mod DIGITS.
REQ-025 an SHALL be ~(1 << index); seg SHALL be the hex glyph of acc nibble index, with acc zero-extended to DIGITS*4 bits.
REQ-026 Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-027 seg and an SHALL be registered, so display reflects acc one cycle after an acc change; value SHALL be the acc register directly.
REQ-028 ovf_led SHALL equal the ovf register.

Reset
REQ-029 While rst=0 at an edge: acc=0, ovf=0, s1=s2=deb=deb_q=0, debounce counter=0, scan counter=0, index=0.
REQ-030 After the first reset edge: value=0, ovf_led=0, an=~1 (only digit 0 on), seg=1000000.
REQ-031 Reset asserted mid-debounce or mid-scan SHALL abort it; a btn held through reset release SHALL then be accepted as a new press.

Verification
REQ-032 Defaults, operand=8'h05, op=0, one clean press -> value=8'h05 at edge 7, ovf_led=0, exactly one enb.
REQ-033 acc=8'hF0, operand=8'h20, op=0, press -> value=8'h10, ovf_led=1; then operand=8'h01, op=0, press -> value=8'h11, ovf_led stays 1.
REQ-034 acc=8'h03, operand=8'h05, op=1, press -> value=8'hFE, ovf_led=1; clr pulse -> value=0, ovf_led=0.
REQ-035 btn glitches high for DEB_CYCLES-1 cycles after synchronization -> no enb, value unchanged; press held 1000 cycles -> exactly one enb.
REQ-036 SCAN_DIV=4, DIGITS=2, acc=8'hA7 -> an cycles 10,01,10... changing every 4 cycles; seg shows 1111000 with an=10 and 0001000 with an=01.
REQ-037 clr and enb coincide -> value=0, ovf_led=0, operation discarded; rst=0 mid-scan -> index=0, an=~1 at the next edge.
